// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory bus bridge: FSM state encoding,
// parameter defaults, the bus payload struct and a counter-width helper.
package dmem_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam int unsigned TIMEOUT_DEF    = 255;
  localparam logic [31:0] FAULT_DATA_DEF = 32'h0000_0000;

  // Registered bus-side request payload.
  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } dmem_bus_t;

  // Counter wide enough to hold the value TIMEOUT.
  function automatic int unsigned cnt_width(input int unsigned timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/dmem_bridge.sv
// dmem_bridge: turns the MEM stage's single-cycle memory request into a
// multi-cycle req/ack bus transaction, stalling the pipeline meanwhile.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   mem_ren/mem_wen            MEM-stage read/write request (write wins)
//   mem_addr, mem_dout         byte address and write data from MEM
//   mem_din                    read data to MEM/WB (registered)
//   mem_stall                  combinational pipeline hold
//   bus_req/we/addr/wdata      registered bus request side
//   bus_ack, bus_rdata         bus completion strobe and read data
//   fault_clr                  clears the sticky fault flags
//   align_err, timeout_err     sticky fault flags
module dmem_bridge
  import dmem_pkg::*;
#(
  parameter int unsigned TIMEOUT    = TIMEOUT_DEF,
  parameter logic [31:0] FAULT_DATA = FAULT_DATA_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_ren,
  input  logic        mem_wen,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_dout,
  output logic [31:0] mem_din,
  output logic        mem_stall,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  input  logic        fault_clr,
  output logic        align_err,
  output logic        timeout_err
);

  localparam int unsigned CNT_W = cnt_width(TIMEOUT);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  dmem_bus_t        bus_q, bus_d;
  logic             req_q, req_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             align_q, align_d;
  logic             tmo_q, tmo_d;
  logic             op;
  logic             set_align;
  logic             set_tmo;

  assign op = mem_ren | mem_wen;

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bus_q   <= '0;
      req_q   <= 1'b0;
      rdata_q <= '0;
      align_q <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bus_q   <= bus_d;
      req_q   <= req_d;
      rdata_q <= rdata_d;
      align_q <= align_d;
      tmo_q   <= tmo_d;
    end
  end

  // Next-state, next-register values and the combinational stall.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bus_d     = bus_q;
    req_d     = req_q;
    rdata_d   = rdata_q;
    set_align = 1'b0;
    set_tmo   = 1'b0;
    mem_stall = 1'b0;

    case (state_q)
      IDLE: begin
        mem_stall = op;
        if (op) begin
          if (mem_addr[1:0] == 2'b00) begin
            bus_d.addr  = {mem_addr[31:2], 2'b00};
            bus_d.we    = mem_wen;
            bus_d.wdata = mem_dout;
            cnt_d       = '0;
            req_d       = 1'b1;
            state_d     = BUSY;
          end else begin
            set_align = 1'b1;
            rdata_d   = FAULT_DATA;
            state_d   = DONE;
          end
        end
      end
      BUSY: begin
        mem_stall = 1'b1;
        cnt_d     = cnt_q + CNT_W'(1);
        // Ack beats a timeout landing in the same cycle.
        if (bus_ack) begin
          rdata_d = bus_q.we ? 32'h0 : bus_rdata;
          req_d   = 1'b0;
          state_d = DONE;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          set_tmo = 1'b1;
          rdata_d = FAULT_DATA;
          req_d   = 1'b0;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        req_d   = 1'b0;
        state_d = IDLE;
      end
    endcase

    // Sticky flags: a set event overrides a simultaneous clear.
    align_d = set_align | (align_q & ~fault_clr);
    tmo_d   = set_tmo | (tmo_q & ~fault_clr);

    // Stall is released immediately while reset is asserted.
    mem_stall = mem_stall & rst_n;
  end

  assign mem_din     = rdata_q;
  assign bus_req     = req_q;
  assign bus_we      = bus_q.we;
  assign bus_addr    = bus_q.addr;
  assign bus_wdata   = bus_q.wdata;
  assign align_err   = align_q;
  assign timeout_err = tmo_q;

endmodule

// File: tb/tb_dmem_bridge.sv
// Scoreboard bench for dmem_bridge: the driver pushes the expected outcome of
// each memory op; a negedge monitor checks it when the DUT releases the stall.
module tb_dmem_bridge;

  localparam logic [31:0] FD = 32'hDEAD_BEEF;

  typedef struct {
    logic [31:0] din;
    logic        align;
    logic        tmo;
    int          stall;
    int          req;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_ren, mem_wen;
  logic [31:0] mem_addr, mem_dout, mem_din;
  logic        mem_stall;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        fault_clr;
  logic        align_err, timeout_err;

  int errors = 0;
  int checks = 0;
  exp_t sb[$];
  int st_n = 0;
  int rq_n = 0;
  int pulses = 0;
  logic req_prev = 1'b0;

  dmem_bridge #(.TIMEOUT(8), .FAULT_DATA(FD)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_dout(mem_dout),
    .mem_din(mem_din), .mem_stall(mem_stall),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .fault_clr(fault_clr), .align_err(align_err), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] din, input logic al, input logic tm,
                      input int st, input int rq, input logic [31:0] a,
                      input logic we, input logic [31:0] wd);
    exp_t e;
    e.din = din; e.align = al; e.tmo = tm; e.stall = st; e.req = rq;
    e.addr = a; e.we = we; e.wdata = wd;
    sb.push_back(e);
  endtask

  // Issue one op and answer it with an ack in the k-th BUSY cycle (k=0: never).
  task automatic do_op(input logic ren, input logic wen, input logic [31:0] addr,
                       input logic [31:0] wd, input int k, input logic [31:0] rd);
    int  n;
    bit  done;
    n = 0;
    done = 1'b0;
    mem_ren = ren; mem_wen = wen; mem_addr = addr; mem_dout = wd;
    for (int c = 0; c < 40 && !done; c++) begin
      @(posedge clk); #1;
      bus_ack = 1'b0;
      if (bus_req) begin
        n++;
        if (n == k) begin
          bus_ack = 1'b1;
          bus_rdata = rd;
        end
      end
      if (!mem_stall) begin
        @(posedge clk); #1;
        mem_ren = 1'b0;
        mem_wen = 1'b0;
        done = 1'b1;
      end
    end
    if (!done) begin
      errors++; checks++;
      $display("FAIL op_timeout: stall never released for addr %h", addr);
      mem_ren = 1'b0; mem_wen = 1'b0;
    end
  endtask

  // Rising edges of bus_req.
  always @(negedge clk) begin
    if (bus_req && !req_prev) pulses++;
    req_prev = bus_req;
  end

  // Monitor: bus fields while requesting, full result when stall releases.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      st_n = 0;
      rq_n = 0;
    end else if (mem_ren || mem_wen) begin
      if (bus_req) begin
        rq_n++;
        if (sb.size() > 0) begin
          chk("bus_addr", bus_addr, sb[0].addr);
          chk("bus_we", 32'(bus_we), 32'(sb[0].we));
          if (sb[0].we) chk("bus_wdata", bus_wdata, sb[0].wdata);
        end
      end
      if (mem_stall) st_n++;
      else begin
        if (sb.size() == 0) begin
          errors++; checks++;
          $display("FAIL unexpected_done: got din %h expected no result", mem_din);
        end else begin
          e = sb.pop_front();
          chk("mem_din", mem_din, e.din);
          chk("align_err", 32'(align_err), 32'(e.align));
          chk("timeout_err", 32'(timeout_err), 32'(e.tmo));
          chk("stall_cycles", 32'(st_n), 32'(e.stall));
          chk("req_cycles", 32'(rq_n), 32'(e.req));
        end
        st_n = 0;
        rq_n = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int p0;
    rst_n = 1'b0;
    mem_ren = 1'b0; mem_wen = 1'b0; mem_addr = '0; mem_dout = '0;
    bus_ack = 1'b0; bus_rdata = '0; fault_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_bus_req", 32'(bus_req), 32'h0);
    chk("rst_stall", 32'(mem_stall), 32'h0);
    chk("rst_din", mem_din, 32'h0);
    chk("rst_bus_addr", bus_addr, 32'h0);
    chk("rst_flags", 32'({align_err, timeout_err}), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Read, immediate ack.
    push(32'h1234_5678, 1'b0, 1'b0, 2, 1, 32'h10, 1'b0, 32'h0);
    do_op(1'b1, 1'b0, 32'h10, 32'h0, 1, 32'h1234_5678);

    // Write, ack after 4 BUSY cycles; read data forced to 0.
    push(32'h0, 1'b0, 1'b0, 5, 4, 32'h20, 1'b1, 32'hCAFE_F00D);
    do_op(1'b0, 1'b1, 32'h20, 32'hCAFE_F00D, 4, 32'h5555_5555);

    // Misaligned read, then clear the flag.
    push(FD, 1'b1, 1'b0, 1, 0, 32'h0, 1'b0, 32'h0);
    do_op(1'b1, 1'b0, 32'h13, 32'h0, 1, 32'h0);
    chk("align_hold", 32'(align_err), 32'h1);
    fault_clr = 1'b1;
    @(posedge clk); #1;
    fault_clr = 1'b0;
    chk("align_cleared", 32'(align_err), 32'h0);

    // Timeout: no ack for TIMEOUT=8 BUSY cycles.
    push(FD, 1'b0, 1'b1, 9, 8, 32'h30, 1'b0, 32'h0);
    do_op(1'b1, 1'b0, 32'h30, 32'h0, 0, 32'h0);
    chk("din_hold_idle", mem_din, FD);

    // Reset in the middle of BUSY, request still asserted.
    mem_ren = 1'b1; mem_addr = 32'h80;
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("midrst_bus_req", 32'(bus_req), 32'h0);
    chk("midrst_stall", 32'(mem_stall), 32'h0);
    chk("midrst_flags", 32'({align_err, timeout_err}), 32'h0);
    chk("midrst_din", mem_din, 32'h0);
    mem_ren = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    push(32'h0BAD_F00D, 1'b0, 1'b0, 3, 2, 32'h84, 1'b0, 32'h0);
    do_op(1'b1, 1'b0, 32'h84, 32'h0, 2, 32'h0BAD_F00D);

    // Ack coincides with the timeout cycle: ack wins.
    push(32'hA5A5_0008, 1'b0, 1'b0, 9, 8, 32'h50, 1'b0, 32'h0);
    do_op(1'b1, 1'b0, 32'h50, 32'h0, 8, 32'hA5A5_0008);

    // Back-to-back reads.
    p0 = pulses;
    push(32'h1111_0040, 1'b0, 1'b0, 2, 1, 32'h40, 1'b0, 32'h0);
    do_op(1'b1, 1'b0, 32'h40, 32'h0, 1, 32'h1111_0040);
    push(32'h2222_0044, 1'b0, 1'b0, 2, 1, 32'h44, 1'b0, 32'h0);
    do_op(1'b1, 1'b0, 32'h44, 32'h0, 1, 32'h2222_0044);
    repeat (2) @(posedge clk);
    #1;
    chk("b2b_pulses", 32'(pulses - p0), 32'h2);

    for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() != 0) begin
      errors++; checks++;
      $display("FAIL sb_drain: got %0d pending expected 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_bridge.md
# dmem_bridge

Data-memory bus bridge placed directly downstream of the pipeline's MEM stage. It converts the MEM stage's single-cycle memory request (`mem_ren`/`mem_wen`/`mem_addr`/`mem_dout`) into a multi-cycle req/ack bus transaction. While the transaction is in flight it stalls the pipeline through `mem_stall`. It returns read data on `mem_din` in the cycle the stall releases, and records alignment and timeout faults in sticky flags.

## Interface
- `TIMEOUT`, 255: maximum BUSY cycles without `bus_ack` before abort; range 1..65535.
- `FAULT_DATA`, 32'h0000_0000: value returned on `mem_din` for aborted or faulted reads.

- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `mem_ren`  in  1  MEM-stage read request.
- `mem_wen`  in  1  MEM-stage write request; wins if asserted together with `mem_ren`.
- `mem_addr`  in  32  byte address from the MEM stage.
- `mem_dout`  in  32  write data from the MEM stage.
- `mem_din`  out  32  read data to the MEM/WB boundary.
- `mem_stall`  out  1  high means hold the pipeline; the controller deasserts `mem_en`/`wb_en` and upstream enables.
- `bus_req`  out  1  bus request; held high until acknowledged.
- `bus_we`  out  1  bus write qualifier.
- `bus_addr`  out  32  word-aligned bus address.
- `bus_wdata`  out  32  bus write data.
- `bus_ack`  in  1  one-cycle completion strobe.
- `bus_rdata`  in  32  read data; valid when `bus_ack` is high.
- `fault_clr`  in  1  synchronous clear of the sticky flags.
- `align_err`  out  1  sticky flag: misaligned access seen.
- `timeout_err`  out  1  sticky flag: bus timeout seen.

## Operation
- Definition: `op = mem_ren | mem_wen`. The FSM has three states: IDLE, BUSY and DONE.
- **IDLE**
  - `mem_stall = op`.
  - If `op` and `mem_addr[1:0] == 0`: latch `bus_addr`, `bus_we = mem_wen`, and `bus_wdata`; clear the timeout counter; go to BUSY.
  - If `op` and the address is misaligned: set `align_err`, load `rdata_q = FAULT_DATA`, issue no bus access, go to DONE.
- **BUSY**
  - Outputs: `bus_req = 1`, `mem_stall = 1`. The counter increments each cycle.
  - On `bus_ack`: `rdata_q = bus_we ? 0 : bus_rdata`; go to DONE.
  - If the counter reaches `TIMEOUT` and `bus_ack` is low in that cycle: set `timeout_err`, `rdata_q = FAULT_DATA`, drop `bus_req`, go to DONE.
  - If `bus_ack` arrives in the same cycle as the timeout, the ack wins.
- **DONE**
  - Outputs: `mem_stall = 0`, `mem_din = rdata_q`. The pipeline advances at the end of this cycle.
  - Next state is always IDLE. The still-present request is not reissued.
- **Outside DONE:** `mem_din` holds `rdata_q`.
- **Bus signals:** `bus_addr`, `bus_we` and `bus_wdata` are registered and stable for the whole of BUSY. `bus_req` is 0 in IDLE and DONE.
- **Sticky flags:** `fault_clr` clears both. If a set event occurs in the same cycle, set wins.
- **Stall ownership:** the block ignores input changes during BUSY and DONE. The pipeline guarantees the inputs are held while `mem_stall` is high.
- **Reset (`rst_n` low, any state):** state → IDLE, counter = 0, all bus outputs = 0, `rdata_q = 0`, both flags = 0, `mem_stall = 0`. An in-flight bus transaction is abandoned. The bus side must tolerate a dropped `bus_req`.

## Timing
- Read or write with ack after k BUSY cycles (k ≥ 1):
  - `op` is seen in cycle 0.
  - BUSY covers cycles 1..k.
  - DONE is cycle k+1.
  - Total occupancy is k+2 cycles; stall is high for k+1 of them.
- Minimum (ack in the first BUSY cycle): 3 cycles, 2 of them stalled.
- Misaligned access: 2 cycles (IDLE, DONE), 1 stalled.
- Timeout: BUSY lasts exactly `TIMEOUT` cycles.
- Back-to-back memory instructions: the IDLE cycle following DONE accepts the next op immediately.
- `mem_stall` is combinational from state and `op`. Every other output is registered.

## Structure
- The shared package `dmem_pkg` holds:
  - the state encoding `IDLE=2'd0, BUSY=2'd1, DONE=2'd2`;
  - the fault-data default;
  - the counter width, `$clog2(TIMEOUT+1)`.
- No sub-module; the FSM, counter and capture registers sit in one module.
- The integrating top ORs `mem_stall` into the pipeline controller's enable logic.

## Test plan
- Read from `0x0000_0010`, ack in the first BUSY cycle with `bus_rdata = 0x1234_5678` → `bus_req` high 1 cycle, `mem_stall` high 2 cycles, and `mem_din = 0x1234_5678` in DONE.
- Write `0xCAFE_F00D` to `0x20`, ack after 4 BUSY cycles → `bus_we = 1`, `bus_wdata` stable for 4 cycles, stall high 5 cycles, `mem_din = 0`.
- Read from `0x0000_0013` → no `bus_req`, stall high 1 cycle, `align_err = 1`, `mem_din = FAULT_DATA`. Assert `fault_clr` → `align_err = 0`.
- `TIMEOUT = 8`, no ack → BUSY for 8 cycles, then `timeout_err = 1` and `mem_din = FAULT_DATA`. Repeat with ack on cycle 8 → no error, real data returned.
- Two reads back to back (addresses `0x40`, `0x44`), each acked immediately → exactly two `bus_req` pulses, with a one-cycle IDLE gap after each DONE.
- Assert `rst_n` low mid-BUSY → `bus_req`, `mem_stall` and flags go to 0 immediately. After release the block is in IDLE and accepts a new read.
